muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle signed multiply/divide engine that owns the architectural HiLo pair.
- Replaces the single-edge MULT/DIV path in the ALU; the ALU keeps OR/ADD/SUB/forward and routes ALUControl 5/7 (MULT/DIV) here.
- MFHI/MFLO (3/4) read hi/lo from this block.
- Issues a stall to the pipeline while an operation is in flight and software touches HiLo.

Parameters:
- WIDTH, 32, operand width; HiLo is 2*WIDTH.
- CW, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op_div  in  1  0 = signed multiply, 1 = signed divide; qualified by start.
- in1  in  WIDTH  multiplicand / dividend (signed).
- in2  in  WIDTH  multiplier / divisor (signed).
- rd_req  in  1  pipeline is issuing MFHI or MFLO this cycle.
- wr_hi  in  1  MTHI: write wdata into hi.
- wr_lo  in  1  MTLO: write wdata into lo.
- wdata  in  WIDTH  data for wr_hi/wr_lo.
- flush  in  1  cancel the in-flight operation (exception/branch squash).
- busy  out  1  operation in flight (state != IDLE); combinational from state.
- stall  out  1  busy & (start | rd_req | wr_hi | wr_lo); combinational.
- done  out  1  one-cycle pulse, registered, when hi/lo are committed.
- hi  out  WIDTH  committed HiLo[2W-1:W] (product high / remainder).
- lo  out  WIDTH  committed HiLo[W-1:0] (product low / quotient).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, done=0, counter=0, working regs=0. Reset mid-operation discards the operation.
- FSM states are IDLE, RUN and FIX.
- IDLE, start=1 (edge 0):
  - Latch |in1|, |in2| as unsigned magnitudes (|-2^31| = 2^31 in W bits).
  - Latch sign flags and op_div; clear accumulator and counter; go to RUN.
- RUN, one iteration per cycle, counter 0..WIDTH-1:
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract, giving quotient bit per step and remainder.
  - At counter==WIDTH-1, go to FIX.
- FIX (edge WIDTH+1 = 33):
  - Apply signs: product negated if sign1^sign2; quotient negated if sign1^sign2; remainder takes dividend's sign.
  - Write hi/lo; done=1 for exactly one cycle; return to IDLE.
- Latency: start sampled at edge 0; hi/lo valid and done high after edge 33; busy high for cycles 0..32 (33 cycles).
- Divide by zero: lo = all ones, hi = in1 (dividend unchanged); still takes the full 33 cycles; no exception.
- Overflow -2^(W-1) / -1: lo = -2^(W-1) (0x80000000), hi = 0.
- Multiply: full 2W signed product, never overflows.
- start while busy: ignored (no re-latch); stall=1 until IDLE, so the requester holds start.
- rd_req while busy: stall=1; hi/lo outputs keep their previous committed value.
- wr_hi/wr_lo:
  - In IDLE, take effect at the next edge.
  - While busy, they are not performed and stall=1.
  - wr_hi and wr_lo together in IDLE write both.
- start and wr_hi/wr_lo in the same IDLE cycle: the write commits and the operation starts; the operation's result later overwrites both.
- flush:
  - In RUN or FIX, return to IDLE next edge; hi/lo unchanged; done stays 0.
  - flush in IDLE with start: start is ignored.
  - flush has priority over FIX commit.
- done deasserts the cycle after it pulses; back-to-back start in that cycle is accepted.

Decomposition:
- Shared package muldiv_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, FIX=2'd2.
  - ALUControl code constants: ALU_MFHI=3, ALU_MFLO=4, ALU_MULT=5, ALU_DIV=7.
  - DIV0_QUOT all-ones constant.
- Natural sub-module: muldiv_step, the combinational single iteration (shift-add or shift-subtract on accumulator/remainder). The top keeps the FSM, counter, sign fixup and HiLo registers.

Test Plan:
- MULT 7 * -3 -> busy 33 cycles; done after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, done at the normal cycle.
- During a MULT, pulse start, rd_req and wr_lo at cycle 10 -> stall=1 each cycle; hi/lo unchanged until done; result matches the first operation only.
- flush at cycle 20 of DIV 50/5 (prior hi/lo=0x11/0x22) -> IDLE next edge, done never pulses, hi/lo stay 0x11/0x22.
- Deassert reset_n at cycle 15 of MULT -> hi=lo=0, busy=0 immediately (async); new MULT 3*4 after release -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // ALUControl codes routed to this block by the ALU decoder
    localparam logic [2:0] ALU_MFHI = 3'd3;
    localparam logic [2:0] ALU_MFLO = 3'd4;
    localparam logic [2:0] ALU_MULT = 3'd5;
    localparam logic [2:0] ALU_DIV  = 3'd7;

    // Quotient returned for divide-by-zero; sliced down to the operand width
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: MSB-first shift-add (multiply) or restoring
// shift-subtract (divide) on the 2W accumulator {rem, quot} / product.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_op,
    input  logic                 i_bit,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_mul;

    assign w_mul  = {i_acc[2*WIDTH-2:0], 1'b0}
                  + {{WIDTH{1'b0}}, (i_bit ? i_op : {WIDTH{1'b0}})};

    // Shifted partial remainder needs W+1 bits; after the restore it fits in W
    assign w_sh   = {i_acc[2*WIDTH-1:WIDTH], i_bit};
    assign w_diff = w_sh - {1'b0, i_op};
    assign w_ge   = (w_sh >= {1'b0, i_op});
    assign w_rem  = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];

    assign o_acc  = i_div ? {w_rem, i_acc[WIDTH-2:0], w_ge} : w_mul;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV engine owning the HiLo pair: 1 setup edge,
// WIDTH iteration edges, 1 sign-fixup/commit edge.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             rd_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mag1, r_mag2, r_hi, r_lo;
    logic               r_sign1, r_sign2, r_div, r_done;
    logic [2*WIDTH-1:0] r_acc;

    logic [CW-1:0]      w_idx;
    logic [WIDTH-1:0]   w_abs1, w_abs2, w_op, w_quot, w_rem;
    logic               w_bit, w_neg;
    logic [2*WIDTH-1:0] w_acc_next, w_prod;

    assign w_abs1 = in1[WIDTH-1] ? -in1 : in1;
    assign w_abs2 = in2[WIDTH-1] ? -in2 : in2;

    // Operand bits are consumed MSB first for both operations
    assign w_idx  = LAST - r_cnt;
    assign w_op   = r_div ? r_mag2 : r_mag1;
    assign w_bit  = r_div ? r_mag1[w_idx] : r_mag2[w_idx];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_op  (w_op),
        .i_bit (w_bit),
        .o_acc (w_acc_next)
    );

    assign w_neg  = r_sign1 ^ r_sign2;
    assign w_prod = w_neg ? -r_acc : r_acc;
    assign w_rem  = r_sign1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    // Zero divisor leaves the dividend magnitude in the remainder half already
    assign w_quot = (r_mag2 == '0) ? DIV0_QUOT[WIDTH-1:0]
                  : (w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mag1  <= '0;
            r_mag2  <= '0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_div   <= 1'b0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    if (start && !flush) begin
                        r_mag1  <= w_abs1;
                        r_mag2  <= w_abs2;
                        r_sign1 <= in1[WIDTH-1];
                        r_sign2 <= in2[WIDTH-1];
                        r_div   <= op_div;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (r_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized back-to-back operations against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, op_div = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        rd_req = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op_div(op_div),
        .in1(in1), .in2(in2), .rd_req(rd_req), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wdata(wdata), .flush(flush), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!div) begin
            p  = sa * sb;
            mh = p[63:32];
            ml = p[31:0];
        end else if (b == 32'd0) begin
            ml = 32'hFFFF_FFFF;
            mh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            ml = 32'h8000_0000;
            mh = 32'd0;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            ml = q[31:0];
            mh = r[31:0];
        end
    endfunction

    // Issues one operation, checks 33-edge latency and the committed result.
    task automatic run_op(input string tag, input bit div, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] eh, el;
        model(div, a, b, eh, el);
        op_div = div; in1 = a; in2 = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_low"}, done, 0);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_latency"}, n, 33);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_idle"}, busy, 0);
        m_hi = eh; m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF;
        c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int n, done_seen;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_100_0", 1'b1, 32'd100, 32'd0);
        run_op("div_m100_0", 1'b1, 32'hFFFF_FF9C, 32'd0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);

        // Requests during a MULT must stall and leave HiLo untouched
        op_div = 1'b0; in1 = 32'h1234_5678; in2 = 32'hF543_2110; start = 1'b1;
        model(1'b0, in1, in2, m_hi, m_lo);
        begin
            logic [31:0] eh, el, ph, pl;
            eh = m_hi; el = m_lo;
            model(1'b1, 32'h8000_0000, 32'h8000_0000, ph, pl);
            model(1'b0, 32'h8000_0000, 32'h8000_0000, ph, pl);
            @(posedge clock); #1;
            start = 1'b0;
            n = 0;
            while (!done && n < 100) begin
                @(posedge clock); #1;
                n++;
                if (n == 10) begin
                    start = 1'b1; op_div = 1'b1; in1 = 32'd99; in2 = 32'd3;
                    rd_req = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
                end
                if (n == 13) begin
                    start = 1'b0; rd_req = 1'b0; wr_lo = 1'b0;
                end
                #1;
                if (n >= 10 && n < 13) begin
                    check("dist_stall", stall, 1);
                    check("dist_hi_hold", hi, ph);
                    check("dist_lo_hold", lo, pl);
                end else if (!done) begin
                    check("dist_nostall", stall, 0);
                end
            end
            check("dist_latency", n, 33);
            check("dist_hi", hi, eh);
            check("dist_lo", lo, el);
        end
        @(posedge clock); #1;
        check("done_pulse_one", done, 0);

        // Direct HiLo writes in IDLE: both together, then individually
        wdata = 32'h5A5A_5A5A; wr_hi = 1'b1; wr_lo = 1'b1;
        @(posedge clock); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_both_hi", hi, 32'h5A5A_5A5A);
        check("wr_both_lo", lo, 32'h5A5A_5A5A);
        wdata = 32'h11; wr_hi = 1'b1;
        @(posedge clock); #1;
        wr_hi = 1'b0; wdata = 32'h22; wr_lo = 1'b1;
        @(posedge clock); #1;
        wr_lo = 1'b0;
        check("wr_hi", hi, 32'h11);
        check("wr_lo", lo, 32'h22);

        // flush together with start in IDLE drops the start
        op_div = 1'b0; in1 = 32'd5; in2 = 32'd6; start = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_idle_busy", busy, 0);

        // flush at cycle 20 of DIV 50/5
        op_div = 1'b1; in1 = 32'd50; in2 = 32'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_busy_after", busy, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) done_seen++;
        end
        check("flush_no_done", done_seen, 0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);

        // async reset at cycle 15 of a MULT
        op_div = 1'b0; in1 = 32'h7FFF_FFFF; in2 = 32'h7FFF_FFFF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op("mul_3_4", 1'b0, 32'd3, 32'd4);

        // Randomized back-to-back operations
        for (int k = 0; k < 30; k++) begin
            run_op("rand", $urandom_range(0, 1) == 1, pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
